// File: rtl/demo_mchn_arb_buf.sv
// N-channel buffered arbiter: per-channel FIFOs merged by a round-robin or strict-priority
// arbiter into one registered valid/ready output tagged with the source channel.
module demo_mchn_arb_buf #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_vld,
  output logic [NUM_CH-1:0]        in_rdy,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     arb_mode,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [NUM_CH-1:0]        ch_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   cand;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [CH_W-1:0]   rr_ptr_d;
  logic              found;
  int unsigned       idx;
  logic              load_en;
  logic              do_pop;

  logic              out_vld_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]   out_ch_q;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      in_rdy[i]   = (count_q[i] != CNT_W'(DEPTH));
      ch_empty[i] = (count_q[i] == '0);
    end
  end

  // Scan order starts at ch0 in strict mode, at rr_ptr in round-robin mode.
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (arb_mode) idx = k;
      else          idx = (32'(rr_ptr_q) + k) % NUM_CH;
      cand = CH_W'(idx);
      if (!found && !ch_empty[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    load_en  = !out_vld_q || out_rdy;
    do_pop   = load_en && found;
    rr_ptr_d = rr_ptr_q;
    if (do_pop && !arb_mode) begin
      rr_ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      push[i]     = in_vld[i] && in_rdy[i];
      pop[i]      = do_pop && (grant == CH_W'(i));
      wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
      unique case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
        2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '{default: '0};
      rd_ptr_q   <= '{default: '0};
      count_q    <= '{default: '0};
      rr_ptr_q   <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      if (do_pop) begin
        out_vld_q  <= 1'b1;
        out_data_q <= mem_q[grant][rd_ptr_q[grant]];
        out_ch_q   <= grant;
      end else if (load_en) begin
        // Nothing to send: drop valid, keep last payload.
        out_vld_q <= 1'b0;
      end
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_ch   = out_ch_q;

endmodule
